// File: rtl/dcache_sram_ctrl_if.sv
// dcache_sram_ctrl_if: signal bundle between the cache pipeline, dcache_sram_ctrl and DCACHE_SRAM0
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_be  load/store request port
//   rsp_valid/rsp_ready/rsp_data                         in-order load response port
//   sram_wr_en/sram_wr_addr/sram_wr_data/sram_wr_byte_en SRAM write port
//   sram_rd_addr/sram_rd_data                            SRAM read port (rd_data unregistered, 1-cycle)
//   init_done                                            SRAM ready for traffic
// Modports: master = pipeline + SRAM side, slave = controller side.
interface dcache_sram_ctrl_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BE_WIDTH-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  sram_wr_en;
    logic [ADDR_WIDTH-1:0] sram_wr_addr;
    logic [DATA_WIDTH-1:0] sram_wr_data;
    logic [BE_WIDTH-1:0]   sram_wr_byte_en;
    logic [ADDR_WIDTH-1:0] sram_rd_addr;
    logic [DATA_WIDTH-1:0] sram_rd_data;
    logic                  init_done;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, sram_rd_data,
        input  req_ready, rsp_valid, rsp_data, sram_wr_en, sram_wr_addr, sram_wr_data,
               sram_wr_byte_en, sram_rd_addr, init_done
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, sram_rd_data,
        output req_ready, rsp_valid, rsp_data, sram_wr_en, sram_wr_addr, sram_wr_data,
               sram_wr_byte_en, sram_rd_addr, init_done
    );
endinterface

// File: rtl/dcache_sram_ctrl.sv
// dcache_sram_ctrl: request-side controller for the 512x32 simple-dual-port data-cache SRAM
// Ports:
//   clk  single clock (SRAM wr_clk/rd_clk tied to it)
//   rst  synchronous active-high reset (also SRAM wr_rst/rd_rst)
//   bus  dcache_sram_ctrl_if.slave: request, response, SRAM ports and init_done
// Define DCACHE_CTRL_INIT_CLEAR_EN to zero-fill the whole SRAM after reset.
module dcache_sram_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int RSP_DEPTH  = 4
) (
    input logic              clk,
    input logic              rst,
    dcache_sram_ctrl_if.slave bus
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 2;
`ifdef DCACHE_CTRL_INIT_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif
    state_t                r_state, w_state_nx;
    logic                  r_wr_en, w_wr_en_nx;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nx;
    logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_nx;
    logic [BE_WIDTH-1:0]   r_wr_be, w_wr_be_nx;
    logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nx;
    logic                  r_ld_v1, r_ld_v2;
    logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_cnt, w_used;
    logic                  w_req_ready, w_acc, w_push, w_pop;

    // r_ld_v1: load address on the SRAM read port; r_ld_v2: SRAM data valid, pushed this edge.
    // Credits count both in-flight stages plus queued entries, so the FIFO can never overflow.
    assign w_used      = r_cnt + CW'(r_ld_v1) + CW'(r_ld_v2);
    assign w_req_ready = (r_state == S_RUN) && (w_used < CW'(RSP_DEPTH));
    assign w_acc       = bus.req_valid && w_req_ready;
    assign w_push      = r_ld_v2;
    assign w_pop       = (r_cnt != '0) && bus.rsp_ready;

    always_comb begin
        w_state_nx   = r_state;
        w_wr_en_nx   = 1'b0;
        w_wr_addr_nx = r_wr_addr;
        w_wr_data_nx = r_wr_data;
        w_wr_be_nx   = r_wr_be;
        w_rd_addr_nx = r_rd_addr;
        case (r_state)
`ifdef DCACHE_CTRL_INIT_CLEAR_EN
            S_IDLE: begin
                w_state_nx   = S_INIT;
                w_wr_en_nx   = 1'b1;
                w_wr_addr_nx = '0;
                w_wr_data_nx = '0;
                w_wr_be_nx   = '1;
            end
            // The write for the last address is on the bus now; leave INIT at the end of this cycle.
            S_INIT: begin
                w_state_nx   = (r_wr_addr == '1) ? S_RUN : S_INIT;
                w_wr_en_nx   = (r_wr_addr != '1);
                w_wr_addr_nx = (r_wr_addr == '1) ? r_wr_addr : r_wr_addr + 1'b1;
            end
`else
            S_IDLE: w_state_nx = S_RUN;
`endif
            S_RUN: begin
                if (w_acc && bus.req_we) begin
                    w_wr_en_nx   = 1'b1;
                    w_wr_addr_nx = bus.req_addr;
                    w_wr_data_nx = bus.req_wdata;
                    w_wr_be_nx   = bus.req_be;
                end
                if (w_acc && !bus.req_we) w_rd_addr_nx = bus.req_addr;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_be   <= '0;
            r_rd_addr <= '0;
            r_ld_v1   <= 1'b0;
            r_ld_v2   <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cnt     <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_wr_en   <= w_wr_en_nx;
            r_wr_addr <= w_wr_addr_nx;
            r_wr_data <= w_wr_data_nx;
            r_wr_be   <= w_wr_be_nx;
            r_rd_addr <= w_rd_addr_nx;
            r_ld_v1   <= w_acc && !bus.req_we;
            r_ld_v2   <= r_ld_v1;
            if (w_push) begin
                r_mem[r_wptr] <= bus.sram_rd_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(w_push && r_cnt == CW'(RSP_DEPTH)));

    assign bus.req_ready       = w_req_ready;
    assign bus.rsp_valid       = (r_cnt != '0);
    assign bus.rsp_data        = r_mem[r_rptr];
    assign bus.sram_wr_en      = r_wr_en;
    assign bus.sram_wr_addr    = r_wr_addr;
    assign bus.sram_wr_data    = r_wr_data;
    assign bus.sram_wr_byte_en = r_wr_be;
    assign bus.sram_rd_addr    = r_rd_addr;
    assign bus.init_done       = (r_state == S_RUN);
endmodule

// File: tb/tb_dcache_sram_ctrl.sv
// tb_dcache_sram_ctrl: self-checking bench for dcache_sram_ctrl with a behavioural 512x32 SRAM
module tb_dcache_sram_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] sram [512];

    dcache_sram_ctrl_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .BE_WIDTH(4)) bus ();
    dcache_sram_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        bus.sram_rd_data <= sram[bus.sram_rd_addr];
        if (bus.sram_wr_en)
            for (int b = 0; b < 4; b++)
                if (bus.sram_wr_byte_en[b]) sram[bus.sram_wr_addr][8*b +: 8] <= bus.sram_wr_data[8*b +: 8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got 0x%08h expected no response", bus.rsp_data);
            end else check("rsp_data", bus.rsp_data, exp_q.pop_front());
        end
    end

    task automatic issue(input logic we, input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
        int t = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
        while (!bus.req_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: got req_ready=0 expected 1 (addr 0x%03h)", a);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, n_acc, bad, n_wr;
        logic hit;
        logic [8:0] a;
        logic [31:0] post_rst_exp;
        vecs[0] = '{1'b1, 9'h005, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 9'h005, 32'h0, 4'h0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 9'h010, 32'h11223344, 4'hF, 32'h0};
        vecs[3] = '{1'b1, 9'h010, 32'hAABBCCDD, 4'b0101, 32'h0};
        vecs[4] = '{1'b0, 9'h010, 32'h0, 4'h0, 32'h11BB33DD};
        vecs[5] = '{1'b1, 9'h1FF, 32'h12345678, 4'hF, 32'h0};
        vecs[6] = '{1'b1, 9'h1FF, 32'h9ABCDEF0, 4'b1000, 32'h0};
        vecs[7] = '{1'b0, 9'h1FF, 32'h0, 4'h0, 32'h9A345678};
        vecs[8] = '{1'b0, 9'h005, 32'h0, 4'h0, 32'hDEADBEEF};
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;

        // Reset: every output low
        repeat (20) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_wr_en", bus.sram_wr_en, 0);
        check("rst_wr_addr", 32'(bus.sram_wr_addr), 0);
        check("rst_wr_data", bus.sram_wr_data, 0);
        check("rst_wr_be", 32'(bus.sram_wr_byte_en), 0);
        check("rst_rd_addr", 32'(bus.sram_rd_addr), 0);
        check("rst_init_done", bus.init_done, 0);
        rst = 1'b0;
`ifdef DCACHE_CTRL_INIT_CLEAR_EN
        n_wr = 0;
        bad = 0;
        for (int c = 0; c < 600 && !bus.init_done; c++) begin
            @(posedge clk);
            #1;
            if (bus.sram_wr_en) begin
                if (bus.sram_wr_addr != 9'(n_wr) || bus.sram_wr_data != 0 || bus.sram_wr_byte_en != 4'hF || bus.req_ready) bad++;
                n_wr++;
            end else if (!bus.init_done) bad++;
        end
        check("init_write_count", n_wr, 512);
        check("init_write_errors", bad, 0);
        check("init_done_after_clear", bus.init_done, 1);
        check("init_wr_en_off", bus.sram_wr_en, 0);
        post_rst_exp = 32'h0;
`else
        check("pre_edge_init_done", bus.init_done, 0);
        @(posedge clk);
        #1;
        check("run_init_done", bus.init_done, 1);
        check("run_req_ready", bus.req_ready, 1);
        post_rst_exp = {23'h0, ~9'h007};
`endif

        // RAW with exact timing
        bus.rsp_ready = 1'b1;
        issue(1'b1, 9'h005, 32'hDEADBEEF, 4'hF);
        check("st_wr_en", bus.sram_wr_en, 1);
        check("st_wr_addr", 32'(bus.sram_wr_addr), 32'h005);
        check("st_wr_data", bus.sram_wr_data, 32'hDEADBEEF);
        check("st_wr_be", 32'(bus.sram_wr_byte_en), 32'hF);
        check("st_no_rsp", bus.rsp_valid, 0);
        issue(1'b0, 9'h005, 32'h0, 4'h0);
        check("ld_wr_en_off", bus.sram_wr_en, 0);
        check("ld_rd_addr", 32'(bus.sram_rd_addr), 32'h005);
        check("raw_lat0", bus.rsp_valid, 0);
        @(posedge clk);
        #1;
        check("raw_lat1", bus.rsp_valid, 0);
        @(posedge clk);
        #1;
        check("raw_lat2_valid", bus.rsp_valid, 1);
        check("raw_lat2_data", bus.rsp_data, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        check("raw_popped", bus.rsp_valid, 0);

        // Table of back-to-back requests, responses scoreboarded in order
        sram[5] = 32'h0;
        mon_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (!vecs[i].we) exp_q.push_back(vecs[i].exp);
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
        end
        drain();

        // Sweep: 1 store/cycle over all addresses, then 1 load/cycle with wrap back to 0
        t0 = cyc;
        for (int i = 0; i < 512; i++) begin
            a = 9'(i);
            issue(1'b1, a, {23'h0, ~a}, 4'hF);
        end
        check("sweep_store_cycles", cyc - t0, 512);
        t0 = cyc;
        for (int i = 0; i < 513; i++) begin
            a = 9'(i);
            exp_q.push_back({23'h0, ~a});
            issue(1'b0, a, 32'h0, 4'h0);
        end
        check("sweep_load_cycles", cyc - t0, 513);
        drain();

        // Backpressure: only RSP_DEPTH loads outstanding
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = 9'(i);
            exp_q.push_back({23'h0, ~a});
        end
        n_acc = 0;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.req_addr = 9'(n_acc);
            hit = bus.req_ready;
            @(posedge clk);
            #1;
            if (hit) n_acc++;
        end
        check("bp_accepted", n_acc, 4);
        check("bp_ready_low", bus.req_ready, 0);
        check("bp_rsp_valid", bus.rsp_valid, 1);
        check("bp_head_data", bus.rsp_data, {23'h0, ~9'h000});
        bus.rsp_ready = 1'b1;
        check("bp_no_comb_path", bus.req_ready, 0);
        @(posedge clk);
        #1;
        check("bp_ready_recover", bus.req_ready, 1);
        issue(1'b0, 9'h004, 32'h0, 4'h0);
        issue(1'b0, 9'h005, 32'h0, 4'h0);
        drain();
        mon_en = 1'b0;

        // Reset with loads in flight and entries queued
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'b0, 9'(i + 8), 32'h0, 4'h0);
        check("mid_fifo_nonempty", bus.rsp_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rsp_valid_cleared", bus.rsp_valid, 0);
        check("mid_req_ready_low", bus.req_ready, 0);
        check("mid_init_done_low", bus.init_done, 0);
        bus.rsp_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 600 && !bus.init_done; c++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) bad++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) bad++;
        end
        check("mid_no_stale_rsp", bad, 0);
        check("mid_init_done", bus.init_done, 1);
        issue(1'b0, 9'h007, 32'h0, 4'h0);
        check("post_lat0", bus.rsp_valid, 0);
        @(posedge clk);
        #1;
        check("post_lat1", bus.rsp_valid, 0);
        @(posedge clk);
        #1;
        check("post_lat2_valid", bus.rsp_valid, 1);
        check("post_lat2_data", bus.rsp_data, post_rst_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
